// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV, DIVU, REM, REMU) for the execute stage.
// Restoring division, one quotient bit per cycle, start/busy/done handshake.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |op1| < |op2|.
module div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            DIVop,
  input  logic [DATA_WIDTH-1:0] DIVop1,
  input  logic [DATA_WIDTH-1:0] DIVop2,
  output logic [DATA_WIDTH-1:0] DIVout,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  is_rem_q, is_rem_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;

  logic                  is_signed;
  logic [DATA_WIDTH-1:0] mag1, mag2;
  logic [DATA_WIDTH:0]   rem_sh, trial;
  logic [DATA_WIDTH-1:0] rem_new, quo_new;

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    is_signed = ~DIVop[0];
    mag1      = (is_signed && DIVop1[DATA_WIDTH-1]) ? ('0 - DIVop1) : DIVop1;
    mag2      = (is_signed && DIVop2[DATA_WIDTH-1]) ? ('0 - DIVop2) : DIVop2;
    rem_sh    = {rem_q, quo_q[DATA_WIDTH-1]};
    trial     = rem_sh - {1'b0, dvsr_q};
    // A clear sign bit on the 33-bit trial means the divisor fits.
    rem_new   = trial[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    quo_new   = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
  end

  // Next-state, datapath update and result selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    dout_d    = dout_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (DIVop2 == '0) begin
            state_d = StDone;
            dout_d  = DIVop[1] ? DIVop1 : '1;
          end else if (is_signed && DIVop1 == MinNeg && DIVop2 == '1) begin
            state_d = StDone;
            dout_d  = DIVop[1] ? '0 : MinNeg;
`ifdef DIV_EARLY_OUT_EN
          end else if (mag1 < mag2) begin
            state_d = StDone;
            dout_d  = DIVop[1] ? DIVop1 : '0;
`endif
          end else begin
            state_d   = StCalc;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = mag1;
            dvsr_d    = mag2;
            is_rem_d  = DIVop[1];
            neg_quo_d = is_signed & (DIVop1[DATA_WIDTH-1] ^ DIVop2[DATA_WIDTH-1]);
            neg_rem_d = is_signed & DIVop1[DATA_WIDTH-1];
          end
        end
      end
      StCalc: begin
        rem_d = rem_new;
        quo_d = quo_new;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          // Sign correction happens here, on the way into DONE.
          if (is_rem_q) dout_d = neg_rem_q ? ('0 - rem_new) : rem_new;
          else          dout_d = neg_quo_q ? ('0 - quo_new) : quo_new;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      dout_q    <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      dout_q    <= dout_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    DIVout = dout_q;
    busy   = (state_q == StCalc);
    done   = (state_q == StDone);
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  DIVop = 2'b00;
  logic [31:0] DIVop1 = '0;
  logic [31:0] DIVop2 = '0;
  logic [31:0] DIVout;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EarlyLat = 0;
`else
  localparam int EarlyLat = 32;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .DIVop  (DIVop),
    .DIVop1 (DIVop1),
    .DIVop2 (DIVop2),
    .DIVout (DIVout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt, output int both,
                        output logic [31:0] res, output logic done_after);
    @(negedge clk);
    DIVop = op; DIVop1 = a; DIVop2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0; both = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      if (busy === 1'b1 && done === 1'b1) both++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy === 1'b1 && done === 1'b1) both++;
    res = DIVout;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (DIVout !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: DIVout=%h busy=%b done=%b, required 0/0/0", DIVout, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors(input string name, input vec_t v[]);
    int lat, bcnt, both;
    logic [31:0] res;
    logic da;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, bcnt, both, res, da);
      n_cmp++;
      if (res !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s[%0d]_result: got %h, required %h", name, i, res, v[i].exp);
      end
      n_cmp++;
      if (lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL %s[%0d]_latency: got %0d, required %0d", name, i, lat, v[i].lat);
      end
      n_cmp++;
      if (bcnt !== v[i].lat || both !== 0) begin
        n_fail++;
        $display("FAIL %s[%0d]_busy: busy cycles %0d overlap %0d, required %0d and 0",
                 name, i, bcnt, both, v[i].lat);
      end
      n_cmp++;
      if (da !== 1'b0) begin
        n_fail++;
        $display("FAIL %s[%0d]_done_pulse: done after pulse %b, required 0", name, i, da);
      end
    end
  endtask

  task automatic test_unsigned();
    vec_t v[] = '{
      '{2'b01, 32'd100, 32'd7, 32'd14, 32},
      '{2'b11, 32'd100, 32'd7, 32'd2, 32},
      '{2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32},
      '{2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32}
    };
    test_vectors("unsigned", v);
  endtask

  task automatic test_signed();
    vec_t v[] = '{
      '{2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32},
      '{2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32},
      '{2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32},
      '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32},
      '{2'b00, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32},
      '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32}
    };
    test_vectors("signed", v);
  endtask

  task automatic test_special();
    vec_t v[] = '{
      '{2'b01, 32'h12345678, 32'h0, 32'hFFFFFFFF, 0},
      '{2'b11, 32'h12345678, 32'h0, 32'h12345678, 0},
      '{2'b00, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF, 0},
      '{2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 0},
      '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0},
      '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0}
    };
    test_vectors("special", v);
  endtask

  task automatic test_early_out();
    vec_t v[] = '{
      '{2'b01, 32'd5, 32'd9, 32'd0, EarlyLat},
      '{2'b11, 32'd5, 32'd9, 32'd5, EarlyLat},
      '{2'b00, 32'hFFFFFFFD, 32'd7, 32'd0, EarlyLat},
      '{2'b10, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFD, EarlyLat}
    };
    test_vectors("early", v);
  endtask

  // A second start while busy must be dropped, not queued.
  task automatic test_ignored_start();
    int n;
    @(negedge clk);
    DIVop = 2'b01; DIVop1 = 32'd1000; DIVop2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == 10) begin
        start = 1'b1; DIVop = 2'b11; DIVop1 = 32'd50; DIVop2 = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    n_cmp++;
    if (DIVout !== 32'd333 || n !== 32) begin
      n_fail++;
      $display("FAIL ignored_start: got %0d after %0d cycles, required 333 after 32", DIVout, n);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || DIVout !== 32'd333) begin
      n_fail++;
      $display("FAIL ignored_start_no_queue: busy=%b done=%b DIVout=%0d, required 0/0/333",
               busy, done, DIVout);
    end
  endtask

  // start held through DONE is re-sampled only in the following IDLE cycle.
  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    DIVop = 2'b01; DIVop1 = 32'd100; DIVop2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL held_start_idle: busy=%b done=%b, required 0/0", busy, done);
    end
    DIVop = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_start_resample: busy=%b, required 1", busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (DIVout !== 32'd2 || n !== 32) begin
      n_fail++;
      $display("FAIL held_start_result: got %0d after %0d cycles, required 2 after 32", DIVout, n);
    end
    @(posedge clk); #1;
  endtask

  // Reset in the middle of CALC aborts with no done pulse.
  task automatic test_reset_mid_calc();
    int dones;
    @(negedge clk);
    DIVop = 2'b01; DIVop1 = 32'd1000; DIVop2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_calc_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || DIVout !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_calc_reset: busy=%b done=%b DIVout=%h, required 0/0/0",
               busy, done, DIVout);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL mid_calc_no_done: busy/done seen %0d cycles, required 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_early_out();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
